// File: rtl/gridx_dma_pkg.sv
// Shared DMA types: the descriptor layout and the command-queue FSM states.
// The DMA engine imports the same package, so both agree on field widths.
package gridx_dma_pkg;

  localparam int DMA_EXT_ADDR_BITS  = 8;
  localparam int DMA_SRAM_ADDR_BITS = 11;
  localparam int DMA_LEN_BITS       = 8;

  // direction: 0 = external memory to SRAM, 1 = SRAM to external memory
  typedef struct packed {
    logic                          direction;
    logic [DMA_EXT_ADDR_BITS-1:0]  extAddr;
    logic [DMA_SRAM_ADDR_BITS-1:0] sramAddr;
    logic [DMA_LEN_BITS-1:0]       length;
  } dma_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HALT
  } dma_state_e;

endpackage

// File: rtl/desc_fifo.sv
// Descriptor FIFO: power-of-two depth, wrapping pointers, occupancy count.
// A flush wins over a push or pop in the same cycle.
module desc_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rdPtr_q];

  assign doPush = push_i && !full_o && !flush_i;
  assign doPop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/dma_cmd_queue.sv
// DMA command queue: buffers descriptors and hands them one at a time to the
// DMA engine, tracking completions, sticky errors and drain events.
module dma_cmd_queue
  import gridx_dma_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int SRAM_ADDR_BITS = 11,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enq_valid,
  input  logic                      enq_direction,
  input  logic [ADDR_BITS-1:0]      enq_ext_addr,
  input  logic [SRAM_ADDR_BITS-1:0] enq_sram_addr,
  input  logic [7:0]                enq_length,
  output logic                      enq_ready,
  output logic                      cmd_valid,
  output logic                      cmd_direction,
  output logic [ADDR_BITS-1:0]      cmd_ext_addr,
  output logic [SRAM_ADDR_BITS-1:0] cmd_sram_addr,
  output logic [7:0]                cmd_length,
  input  logic                      cmd_ready,
  input  logic                      cmd_done,
  input  logic                      cmd_error,
  input  logic                      flush,
  input  logic                      err_clear,
  output logic [$clog2(DEPTH):0]    queue_count,
  output logic [7:0]                done_count,
  output logic                      error_sticky,
  output logic                      idle,
  output logic                      drained_irq
);

  dma_desc_t                enqDesc, headDesc;
  logic                     fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [$clog2(DEPTH):0]   fifoCount;

  dma_state_e state_q;
  logic       notEmpty_q;
  logic       cmdValid_q;
  logic [7:0] doneCount_q;
  logic       errorSticky_q;
  logic       drainedIrq_q;

  // Address widths come from the shared package; the parameters must not exceed them.
  always_comb begin
    enqDesc.direction = enq_direction;
    enqDesc.extAddr   = DMA_EXT_ADDR_BITS'(enq_ext_addr);
    enqDesc.sramAddr  = DMA_SRAM_ADDR_BITS'(enq_sram_addr);
    enqDesc.length    = enq_length;
  end

  assign fifoPush = enq_valid && !fifoFull && !flush;
  assign fifoPop  = (state_q == ISSUE) && cmd_ready && !flush;

  desc_fifo #(
    .WIDTH ($bits(dma_desc_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (flush),
    .wdata_i (enqDesc),
    .rdata_o (headDesc),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // IDLE looks at a registered copy of "FIFO non-empty", which gives the
  // two-edge enqueue-to-issue latency; a flush clears it so IDLE never
  // issues from a queue that was just emptied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      notEmpty_q    <= 1'b0;
      cmdValid_q    <= 1'b0;
      doneCount_q   <= 8'd0;
      errorSticky_q <= 1'b0;
      drainedIrq_q  <= 1'b0;
    end else begin
      notEmpty_q   <= !fifoEmpty && !flush;
      drainedIrq_q <= 1'b0;
      if (err_clear) errorSticky_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (notEmpty_q && !flush) begin
            state_q    <= ISSUE;
            cmdValid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (flush) begin
            state_q    <= IDLE;
            cmdValid_q <= 1'b0;
          end else if (cmd_ready) begin
            state_q    <= WAIT;
            cmdValid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cmd_error) begin
            state_q       <= HALT;
            errorSticky_q <= 1'b1;
          end else if (cmd_done) begin
            state_q      <= IDLE;
            doneCount_q  <= doneCount_q + 8'd1;
            drainedIrq_q <= fifoEmpty;
          end
        end
        HALT: begin
          if (err_clear) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enq_ready     = !fifoFull;
  assign cmd_valid     = cmdValid_q;
  assign cmd_direction = headDesc.direction;
  assign cmd_ext_addr  = ADDR_BITS'(headDesc.extAddr);
  assign cmd_sram_addr = SRAM_ADDR_BITS'(headDesc.sramAddr);
  assign cmd_length    = headDesc.length;
  assign queue_count   = fifoCount;
  assign done_count    = doneCount_q;
  assign error_sticky  = errorSticky_q;
  assign idle          = (state_q == IDLE) && fifoEmpty;
  assign drained_irq   = drainedIrq_q;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Self-checking bench for dma_cmd_queue: a vector table for the basic flow
// plus directed sequences for backpressure, halt, flush and mid-run reset.
module tb_dma_cmd_queue;

  logic        clk;
  logic        reset;
  logic        enqValid;
  logic        enqDirection;
  logic [7:0]  enqExtAddr;
  logic [10:0] enqSramAddr;
  logic [7:0]  enqLength;
  logic        enqReady;
  logic        cmdValid;
  logic        cmdDirection;
  logic [7:0]  cmdExtAddr;
  logic [10:0] cmdSramAddr;
  logic [7:0]  cmdLength;
  logic        cmdReady;
  logic        cmdDone;
  logic        cmdError;
  logic        flush;
  logic        errClear;
  logic [2:0]  queueCount;
  logic [7:0]  doneCount;
  logic        errorSticky;
  logic        idle;
  logic        drainedIrq;

  int checks = 0;
  int errors = 0;

  dma_cmd_queue #(
    .ADDR_BITS      (8),
    .SRAM_ADDR_BITS (11),
    .DEPTH          (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enq_valid     (enqValid),
    .enq_direction (enqDirection),
    .enq_ext_addr  (enqExtAddr),
    .enq_sram_addr (enqSramAddr),
    .enq_length    (enqLength),
    .enq_ready     (enqReady),
    .cmd_valid     (cmdValid),
    .cmd_direction (cmdDirection),
    .cmd_ext_addr  (cmdExtAddr),
    .cmd_sram_addr (cmdSramAddr),
    .cmd_length    (cmdLength),
    .cmd_ready     (cmdReady),
    .cmd_done      (cmdDone),
    .cmd_error     (cmdError),
    .flush         (flush),
    .err_clear     (errClear),
    .queue_count   (queueCount),
    .done_count    (doneCount),
    .error_sticky  (errorSticky),
    .idle          (idle),
    .drained_irq   (drainedIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        enqValid;
    logic        dir;
    logic [7:0]  ext;
    logic [10:0] sram;
    logic [7:0]  len;
    logic        rdy;
    logic        done;
    logic        err;
    logic        flush;
    logic        clr;
    logic        eValid;
    logic [2:0]  eCount;
    logic        eEnqRdy;
    logic [7:0]  eDone;
    logic        eSticky;
    logic        eIdle;
    logic        eIrq;
    logic        eDir;
    logic [7:0]  eExt;
    logic [10:0] eSram;
    logic [7:0]  eLen;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    enqValid     = 1'b0;
    enqDirection = 1'b0;
    enqExtAddr   = 8'h00;
    enqSramAddr  = 11'h000;
    enqLength    = 8'd0;
    cmdReady     = 1'b0;
    cmdDone      = 1'b0;
    cmdError     = 1'b0;
    flush        = 1'b0;
    errClear     = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    enqValid     = v.enqValid;
    enqDirection = v.dir;
    enqExtAddr   = v.ext;
    enqSramAddr  = v.sram;
    enqLength    = v.len;
    cmdReady     = v.rdy;
    cmdDone      = v.done;
    cmdError     = v.err;
    flush        = v.flush;
    errClear     = v.clr;
    tick();
  endtask

  task automatic enqueueOne(input logic dir, input logic [7:0] ext, input logic [10:0] sram, input logic [7:0] len);
    enqValid     = 1'b1;
    enqDirection = dir;
    enqExtAddr   = ext;
    enqSramAddr  = sram;
    enqLength    = len;
    tick();
    enqValid     = 1'b0;
  endtask

  // An expired bound shows up as a failed cmd_valid comparison.
  task automatic waitValid(input string name);
    int n = 0;
    while (cmdValid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput(name, {31'd0, cmdValid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawValid;

    vecs[0]  = '{1'b1,1'b0,8'h10,11'h020,8'd4, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd1,1'b1,8'd0,1'b0,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[1]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd1,1'b1,8'd0,1'b0,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[2]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,3'd1,1'b1,8'd0,1'b0,1'b0,1'b0, 1'b0,8'h10,11'h020,8'd4};
    vecs[3]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,1'b1,8'd0,1'b0,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[4]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0,1'b1,8'd1,1'b0,1'b1,1'b1, 1'b0,8'h00,11'h000,8'd0};
    vecs[5]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,1'b1,8'd1,1'b0,1'b1,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[6]  = '{1'b1,1'b1,8'hAB,11'h7FF,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd1,1'b1,8'd1,1'b0,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[7]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd1,1'b1,8'd1,1'b0,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[8]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,3'd1,1'b1,8'd1,1'b0,1'b0,1'b0, 1'b1,8'hAB,11'h7FF,8'd0};
    vecs[9]  = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,3'd1,1'b1,8'd1,1'b0,1'b0,1'b0, 1'b1,8'hAB,11'h7FF,8'd0};
    vecs[10] = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,1'b1,8'd1,1'b0,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[11] = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,3'd0,1'b1,8'd1,1'b1,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[12] = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,1'b1,8'd1,1'b1,1'b0,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[13] = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,3'd0,1'b1,8'd1,1'b0,1'b1,1'b0, 1'b0,8'h00,11'h000,8'd0};
    vecs[14] = '{1'b0,1'b0,8'h00,11'h000,8'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,3'd0,1'b1,8'd1,1'b0,1'b1,1'b0, 1'b0,8'h00,11'h000,8'd0};

    clearInputs();
    reset = 1'b1;
    #1;
    checkOutput("rst.valid",    {31'd0, cmdValid},    32'd0);
    checkOutput("rst.enqReady", {31'd0, enqReady},    32'd1);
    checkOutput("rst.count",    {29'd0, queueCount},  32'd0);
    checkOutput("rst.done",     {24'd0, doneCount},   32'd0);
    checkOutput("rst.sticky",   {31'd0, errorSticky}, 32'd0);
    checkOutput("rst.idle",     {31'd0, idle},        32'd1);
    checkOutput("rst.irq",      {31'd0, drainedIrq},  32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Basic flow, zero-length descriptor, done+error together, stray pulses.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d.valid", i),    {31'd0, cmdValid},    {31'd0, vecs[i].eValid});
      checkOutput($sformatf("row%0d.count", i),    {29'd0, queueCount},  {29'd0, vecs[i].eCount});
      checkOutput($sformatf("row%0d.enqReady", i), {31'd0, enqReady},    {31'd0, vecs[i].eEnqRdy});
      checkOutput($sformatf("row%0d.done", i),     {24'd0, doneCount},   {24'd0, vecs[i].eDone});
      checkOutput($sformatf("row%0d.sticky", i),   {31'd0, errorSticky}, {31'd0, vecs[i].eSticky});
      checkOutput($sformatf("row%0d.idle", i),     {31'd0, idle},        {31'd0, vecs[i].eIdle});
      checkOutput($sformatf("row%0d.irq", i),      {31'd0, drainedIrq},  {31'd0, vecs[i].eIrq});
      if (vecs[i].eValid) begin
        checkOutput($sformatf("row%0d.dir", i),  {31'd0, cmdDirection}, {31'd0, vecs[i].eDir});
        checkOutput($sformatf("row%0d.ext", i),  {24'd0, cmdExtAddr},   {24'd0, vecs[i].eExt});
        checkOutput($sformatf("row%0d.sram", i), {21'd0, cmdSramAddr},  {21'd0, vecs[i].eSram});
        checkOutput($sformatf("row%0d.len", i),  {24'd0, cmdLength},    {24'd0, vecs[i].eLen});
      end
    end
    clearInputs();

    // Backpressure: five enqueues into a depth-4 queue, fifth dropped.
    for (int i = 0; i < 5; i++) begin
      enqueueOne(i[0], 8'h20 + 8'(i), 11'h100 + 11'(i), 8'(i + 1));
      if (i == 3) checkOutput("fill.enqReadyAfter4", {31'd0, enqReady}, 32'd0);
    end
    checkOutput("fill.count", {29'd0, queueCount}, 32'd4);
    cmdReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitValid($sformatf("drain%0d.valid", k));
      checkOutput($sformatf("drain%0d.ext", k),  {24'd0, cmdExtAddr},  32'h20 + 32'(k));
      checkOutput($sformatf("drain%0d.sram", k), {21'd0, cmdSramAddr}, 32'h100 + 32'(k));
      checkOutput($sformatf("drain%0d.len", k),  {24'd0, cmdLength},   32'(k + 1));
      tick();
      cmdDone = 1'b1;
      tick();
      cmdDone = 1'b0;
      checkOutput($sformatf("drain%0d.irq", k), {31'd0, drainedIrq}, (k == 3) ? 32'd1 : 32'd0);
    end
    cmdReady = 1'b0;
    checkOutput("drain.done",  {24'd0, doneCount},  32'd5);
    checkOutput("drain.count", {29'd0, queueCount}, 32'd0);
    checkOutput("drain.idle",  {31'd0, idle},       32'd1);

    // Error in WAIT halts the queue with the remaining entries intact.
    for (int i = 0; i < 3; i++) enqueueOne(1'b0, 8'h40 + 8'(i), 11'h200, 8'd8);
    waitValid("halt.firstValid");
    checkOutput("halt.firstExt", {24'd0, cmdExtAddr}, 32'h40);
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
    cmdError = 1'b1;
    tick();
    cmdError = 1'b0;
    checkOutput("halt.sticky", {31'd0, errorSticky}, 32'd1);
    checkOutput("halt.idle",   {31'd0, idle},        32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmdValid !== 1'b0) sawValid = 1'b1;
    end
    checkOutput("halt.noIssue", {31'd0, sawValid},   32'd0);
    checkOutput("halt.count",   {29'd0, queueCount}, 32'd2);
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    checkOutput("halt.clearSticky", {31'd0, errorSticky}, 32'd0);
    waitValid("halt.resumeValid");
    checkOutput("halt.resumeExt", {24'd0, cmdExtAddr}, 32'h41);
    flush    = 1'b1;
    cmdReady = 1'b1;
    enqValid = 1'b1;
    tick();
    clearInputs();
    checkOutput("flushIssue1.valid", {31'd0, cmdValid},   32'd0);
    checkOutput("flushIssue1.count", {29'd0, queueCount}, 32'd0);
    checkOutput("flushIssue1.idle",  {31'd0, idle},       32'd1);
    checkOutput("flushIssue1.done",  {24'd0, doneCount},  32'd5);

    // Flush with three queued while ISSUE is stalled.
    for (int i = 0; i < 3; i++) enqueueOne(1'b1, 8'h50 + 8'(i), 11'h300, 8'd2);
    waitValid("flushIssue3.valid");
    checkOutput("flushIssue3.countBefore", {29'd0, queueCount}, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushIssue3.valid0", {31'd0, cmdValid},   32'd0);
    checkOutput("flushIssue3.count",  {29'd0, queueCount}, 32'd0);
    checkOutput("flushIssue3.idle",   {31'd0, idle},       32'd1);

    // Flush during WAIT keeps the in-flight command alive.
    enqueueOne(1'b0, 8'h60, 11'h060, 8'd1);
    enqueueOne(1'b0, 8'h61, 11'h061, 8'd1);
    waitValid("flushWait.valid");
    checkOutput("flushWait.ext", {24'd0, cmdExtAddr}, 32'h60);
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
    checkOutput("flushWait.countBefore", {29'd0, queueCount}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushWait.count", {29'd0, queueCount}, 32'd0);
    checkOutput("flushWait.idle",  {31'd0, idle},       32'd0);
    cmdDone = 1'b1;
    tick();
    cmdDone = 1'b0;
    checkOutput("flushWait.done",    {24'd0, doneCount},  32'd6);
    checkOutput("flushWait.irq",     {31'd0, drainedIrq}, 32'd1);
    checkOutput("flushWait.idleEnd", {31'd0, idle},       32'd1);

    // Asynchronous reset in the middle of WAIT.
    for (int i = 0; i < 3; i++) enqueueOne(1'b0, 8'h70 + 8'(i), 11'h070, 8'd3);
    waitValid("midReset.valid");
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
    checkOutput("midReset.countBefore", {29'd0, queueCount}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midReset.valid",    {31'd0, cmdValid},    32'd0);
    checkOutput("midReset.enqReady", {31'd0, enqReady},    32'd1);
    checkOutput("midReset.count",    {29'd0, queueCount},  32'd0);
    checkOutput("midReset.done",     {24'd0, doneCount},   32'd0);
    checkOutput("midReset.sticky",   {31'd0, errorSticky}, 32'd0);
    checkOutput("midReset.idle",     {31'd0, idle},        32'd1);
    checkOutput("midReset.irq",      {31'd0, drainedIrq},  32'd0);
    tick();
    reset = 1'b0;
    cmdReady = 1'b1;
    enqueueOne(1'b1, 8'h80, 11'h480, 8'd9);
    waitValid("postReset.valid");
    checkOutput("postReset.ext",  {24'd0, cmdExtAddr},   32'h80);
    checkOutput("postReset.dir",  {31'd0, cmdDirection}, 32'd1);
    checkOutput("postReset.sram", {21'd0, cmdSramAddr},  32'h480);
    tick();
    cmdReady = 1'b0;
    cmdDone  = 1'b1;
    tick();
    cmdDone  = 1'b0;
    checkOutput("postReset.done", {24'd0, doneCount}, 32'd1);
    checkOutput("postReset.idle", {31'd0, idle},      32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
